// File: rtl/cpu_bus_bridge.sv
// 65C02 bus bridge: decodes each phi2 cycle into IO/ROM/RAM and strobes the selected device.
// Latency 1+W clocks to strobe. The core is stalled through rdy; IO holds its strobe until io_ack or timeout.
module cpu_bus_bridge #(
  parameter logic [15:0] ROM_BASE   = 16'hE000,
  parameter logic [15:0] IO_BASE    = 16'hD000,
  parameter int unsigned RAM_WAIT   = 1,
  parameter int unsigned ROM_WAIT   = 0,
  parameter int unsigned IO_WAIT    = 2,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic [15:0] a,
  input  logic        rwb,
  input  logic        sync,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic        cs_ram,
  output logic        cs_rom,
  output logic        cs_io,
  input  logic [7:0]  mem_rdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        fetch,
  input  logic        err_clr,
  output logic        rom_wr_err,
  output logic        io_timeout_err,
  output logic        overrun_err
);

  typedef enum logic [1:0] {IDLE, WAIT, STROBE, DONE} state_t;

  localparam logic [15:0] IO_LAST = IO_BASE + 16'h00FF;
  localparam logic [2:0]  RAM_W   = 3'(RAM_WAIT);
  localparam logic [2:0]  ROM_W   = 3'(ROM_WAIT);
  localparam logic [2:0]  IO_W    = 3'(IO_WAIT);
  localparam logic [7:0]  TO_LAST = 8'(IO_TIMEOUT - 1);

  state_t     state;
  logic       phi2_q;
  logic       rwb_q;
  logic       active;
  logic [2:0] cnt;
  logic [7:0] tcnt;
  logic       start;
  logic       io_hit;
  logic       rom_hit;
  logic [2:0] w_sel;

  assign start = phi2 & ~phi2_q;

  always_comb begin
    io_hit  = (a >= IO_BASE) && (a <= IO_LAST);
    rom_hit = (a >= ROM_BASE) && !io_hit;
    w_sel   = io_hit ? IO_W : (rom_hit ? ROM_W : RAM_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      phi2_q         <= 1'b0;
      rwb_q          <= 1'b1;
      active         <= 1'b0;
      cnt            <= 3'd0;
      tcnt           <= 8'd0;
      cpu_rdata      <= 8'hFF;
      rdy            <= 1'b1;
      mem_addr       <= 16'h0000;
      mem_wdata      <= 8'h00;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      cs_ram         <= 1'b0;
      cs_rom         <= 1'b0;
      cs_io          <= 1'b0;
      fetch          <= 1'b0;
      rom_wr_err     <= 1'b0;
      io_timeout_err <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      phi2_q <= phi2;
      // Clear first so that a coincident set below takes precedence.
      if (err_clr) begin
        rom_wr_err     <= 1'b0;
        io_timeout_err <= 1'b0;
        overrun_err    <= 1'b0;
      end
      if (start && state != IDLE) overrun_err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= a;
            mem_wdata <= cpu_wdata;
            fetch     <= sync;
            rwb_q     <= rwb;
            cs_io     <= io_hit;
            cs_rom    <= rom_hit;
            cs_ram    <= !io_hit && !rom_hit;
            active    <= 1'b0;
            if (w_sel == 3'd0 && !io_hit) begin
              state <= STROBE;
            end else begin
              rdy <= 1'b0;
              if (w_sel != 3'd0) begin
                cnt   <= w_sel;
                state <= WAIT;
              end else begin
                state <= STROBE;
              end
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= STROBE;
        end
        STROBE: begin
          if (!active) begin
            // First STROBE clock raises the strobe; later clocks complete it.
            active <= 1'b1;
            tcnt   <= 8'd0;
            mem_re <= rwb_q;
            mem_we <= !rwb_q && !cs_rom;
            if (cs_rom && !rwb_q) rom_wr_err <= 1'b1;
          end else if (!cs_io || io_ack || tcnt == TO_LAST) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            rdy    <= 1'b1;
            active <= 1'b0;
            state  <= DONE;
            if (rwb_q) cpu_rdata <= !cs_io ? mem_rdata : (io_ack ? io_rdata : 8'hFF);
            if (cs_io && !io_ack) io_timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DONE: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          cs_ram <= 1'b0;
          cs_rom <= 1'b0;
          cs_io  <= 1'b0;
          rdy    <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Scoreboard bench for cpu_bus_bridge: expected read data / write beats are queued at stimulus time.
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset, phi2, rwb, sync, io_ack, err_clr;
  logic [15:0] a;
  logic [7:0]  cpu_wdata, mem_rdata, io_rdata;
  logic [7:0]  cpu_rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic        rdy, mem_re, mem_we, cs_ram, cs_rom, cs_io, fetch;
  logic        rom_wr_err, io_timeout_err, overrun_err;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   chk = 0;
  int   pass = 0;
  int   we_cnt = 0;
  int   rdy_low_cnt = 0;

  cpu_bus_bridge dut (
    .clk(clk), .reset(reset), .phi2(phi2), .a(a), .rwb(rwb), .sync(sync),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .rdy(rdy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .cs_ram(cs_ram),
    .cs_rom(cs_rom), .cs_io(cs_io), .mem_rdata(mem_rdata), .io_rdata(io_rdata),
    .io_ack(io_ack), .fetch(fetch), .err_clr(err_clr), .rom_wr_err(rom_wr_err),
    .io_timeout_err(io_timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
    if (rdy !== 1'b1) rdy_low_cnt <= rdy_low_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after edge k, the edge that sees the phi2 rise.
  task automatic start_cycle(input logic [15:0] addr, input logic rw,
                             input logic [7:0] wd, input logic sy);
    phi2 = 1'b0;
    tick();
    a = addr; rwb = rw; cpu_wdata = wd; sync = sy; phi2 = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; phi2 = 1'b0; a = 16'h1234; rwb = 1'b0; sync = 1'b1; cpu_wdata = 8'h77;
    mem_rdata = 8'h00; io_rdata = 8'h00; io_ack = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk++; if (rdy !== 1'b1) $display("FAIL reset_rdy got=%0h exp=1", rdy); else pass++;
    chk++; if (cpu_rdata !== 8'hFF) $display("FAIL reset_rdata got=%0h exp=ff", cpu_rdata); else pass++;
    chk++; if ({mem_addr, mem_wdata} !== 24'h0) $display("FAIL reset_addr_wdata got=%0h exp=0", {mem_addr, mem_wdata}); else pass++;
    chk++; if ({mem_re, mem_we, cs_ram, cs_rom, cs_io, fetch, rom_wr_err, io_timeout_err, overrun_err} !== 9'h0)
      $display("FAIL reset_flags got=%0b exp=0", {mem_re, mem_we, cs_ram, cs_rom, cs_io, fetch, rom_wr_err, io_timeout_err, overrun_err}); else pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rom_read();
    int rl0;
    rl0 = rdy_low_cnt;
    mem_rdata = 8'h00;
    sb.push_back('{addr: 16'hFFFC, data: 8'h00});
    start_cycle(16'hFFFC, 1'b1, 8'h00, 1'b1);
    chk++; if ({cs_rom, mem_re, fetch} !== 3'b101) $display("FAIL rom_k got=%0b exp=101", {cs_rom, mem_re, fetch}); else pass++;
    chk++; if (mem_addr !== 16'hFFFC) $display("FAIL rom_addr got=%0h exp=fffc", mem_addr); else pass++;
    tick();
    chk++; if ({mem_re, cs_rom} !== 2'b11) $display("FAIL rom_strobe got=%0b exp=11", {mem_re, cs_rom}); else pass++;
    tick();
    e = sb.pop_front();
    chk++; if (mem_re !== 1'b0) $display("FAIL rom_strobe_len got=%0h exp=0", mem_re); else pass++;
    chk++; if (cpu_rdata !== e.data) $display("FAIL rom_rdata got=%0h exp=%0h", cpu_rdata, e.data); else pass++;
    tick();
    chk++; if (cs_rom !== 1'b0) $display("FAIL rom_cs_drop got=%0h exp=0", cs_rom); else pass++;
    chk++; if (rdy_low_cnt != rl0) $display("FAIL rom_rdy_low got=%0d exp=%0d", rdy_low_cnt, rl0); else pass++;
  endtask

  task automatic test_ram_write();
    sb.push_back('{addr: 16'h0200, data: 8'h5A});
    start_cycle(16'h0200, 1'b0, 8'h5A, 1'b0);
    cpu_wdata = 8'hFF;
    chk++; if ({rdy, cs_ram, mem_we} !== 3'b010) $display("FAIL ram_k got=%0b exp=010", {rdy, cs_ram, mem_we}); else pass++;
    tick();
    chk++; if ({rdy, mem_we} !== 2'b00) $display("FAIL ram_k1 got=%0b exp=00", {rdy, mem_we}); else pass++;
    tick();
    e = sb.pop_front();
    chk++; if (mem_we !== 1'b1) $display("FAIL ram_we got=%0h exp=1", mem_we); else pass++;
    chk++; if ({mem_addr, mem_wdata} !== {e.addr, e.data}) $display("FAIL ram_beat got=%0h exp=%0h", {mem_addr, mem_wdata}, {e.addr, e.data}); else pass++;
    tick();
    chk++; if ({rdy, mem_we} !== 2'b10) $display("FAIL ram_k3 got=%0b exp=10", {rdy, mem_we}); else pass++;
    chk++; if (cpu_rdata !== 8'h00) $display("FAIL ram_rdata_kept got=%0h exp=00", cpu_rdata); else pass++;
    tick();
  endtask

  task automatic test_io_read();
    sb.push_back('{addr: 16'hD010, data: 8'hA5});
    start_cycle(16'hD010, 1'b1, 8'h00, 1'b0);
    chk++; if ({rdy, cs_io} !== 2'b01) $display("FAIL io_k got=%0b exp=01", {rdy, cs_io}); else pass++;
    tick(); tick();
    chk++; if (mem_re !== 1'b0) $display("FAIL io_early_re got=%0h exp=0", mem_re); else pass++;
    tick();
    chk++; if ({mem_re, rdy} !== 2'b10) $display("FAIL io_re got=%0b exp=10", {mem_re, rdy}); else pass++;
    tick(); tick();
    chk++; if ({mem_re, rdy} !== 2'b10) $display("FAIL io_hold got=%0b exp=10", {mem_re, rdy}); else pass++;
    io_ack = 1'b1; io_rdata = 8'hA5;
    tick();
    io_ack = 1'b0; io_rdata = 8'h00;
    e = sb.pop_front();
    chk++; if (cpu_rdata !== e.data) $display("FAIL io_rdata got=%0h exp=%0h", cpu_rdata, e.data); else pass++;
    chk++; if ({mem_re, rdy} !== 2'b01) $display("FAIL io_done got=%0b exp=01", {mem_re, rdy}); else pass++;
    tick();
    chk++; if ({cs_io, rom_wr_err, io_timeout_err, overrun_err} !== 4'h0)
      $display("FAIL io_errs got=%0b exp=0", {cs_io, rom_wr_err, io_timeout_err, overrun_err}); else pass++;
  endtask

  task automatic test_io_timeout();
    int re_cycles;
    bit done;
    re_cycles = 0; done = 0;
    sb.push_back('{addr: 16'hD020, data: 8'hFF});
    start_cycle(16'hD020, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (mem_re === 1'b1) re_cycles++;
      if (rdy === 1'b1) done = 1;
    end
    chk++; if (!done) $display("FAIL io_to_finish got=busy exp=rdy"); else pass++;
    chk++; if (re_cycles != 15) $display("FAIL io_to_len got=%0d exp=15", re_cycles); else pass++;
    e = sb.pop_front();
    chk++; if (cpu_rdata !== e.data) $display("FAIL io_to_rdata got=%0h exp=%0h", cpu_rdata, e.data); else pass++;
    chk++; if (io_timeout_err !== 1'b1) $display("FAIL io_to_err got=%0h exp=1", io_timeout_err); else pass++;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk++; if (io_timeout_err !== 1'b0) $display("FAIL io_to_clr got=%0h exp=0", io_timeout_err); else pass++;
  endtask

  task automatic test_rom_write_overrun();
    int we0;
    we0 = we_cnt;
    err_clr = 1'b1;
    start_cycle(16'hE123, 1'b0, 8'h33, 1'b0);
    chk++; if ({cs_rom, rdy} !== 2'b11) $display("FAIL romw_k got=%0b exp=11", {cs_rom, rdy}); else pass++;
    tick();
    chk++; if (rom_wr_err !== 1'b1) $display("FAIL romw_err_set_wins got=%0h exp=1", rom_wr_err); else pass++;
    tick();
    chk++; if (rom_wr_err !== 1'b0) $display("FAIL romw_err_clr got=%0h exp=0", rom_wr_err); else pass++;
    err_clr = 1'b0;
    tick();
    chk++; if (we_cnt != we0) $display("FAIL romw_no_we got=%0d exp=%0d", we_cnt - we0, 0); else pass++;

    sb.push_back('{addr: 16'hD005, data: 8'h77});
    start_cycle(16'hD005, 1'b0, 8'h77, 1'b0);
    phi2 = 1'b0; a = 16'h0400; cpu_wdata = 8'h11;
    tick();
    phi2 = 1'b1;
    tick();
    chk++; if (overrun_err !== 1'b1) $display("FAIL ovr_err got=%0h exp=1", overrun_err); else pass++;
    tick();
    e = sb.pop_front();
    chk++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, e.addr, e.data})
      $display("FAIL ovr_first_beat got=%0h exp=%0h", {mem_we, mem_addr, mem_wdata}, {1'b1, e.addr, e.data}); else pass++;
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    chk++; if ({mem_we, rdy, io_timeout_err} !== 3'b010) $display("FAIL ovr_done got=%0b exp=010", {mem_we, rdy, io_timeout_err}); else pass++;
    tick();
    chk++; if ({cs_io, cs_ram} !== 2'b00) $display("FAIL ovr_no_second got=%0b exp=00", {cs_io, cs_ram}); else pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk++; if (overrun_err !== 1'b0) $display("FAIL ovr_clr got=%0h exp=0", overrun_err); else pass++;
  endtask

  task automatic test_reset_mid_io();
    bit seen;
    seen = 0;
    start_cycle(16'hD030, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (mem_re === 1'b1) seen = 1;
    end
    chk++; if (!seen) $display("FAIL rst_io_strobe got=0 exp=1"); else pass++;
    #2 reset = 1'b1;
    #1;
    chk++; if ({mem_re, mem_we, cs_io, rdy} !== 4'b0001) $display("FAIL rst_async got=%0b exp=0001", {mem_re, mem_we, cs_io, rdy}); else pass++;
    tick();
    reset = 1'b0;
    mem_rdata = 8'h3C;
    sb.push_back('{addr: 16'h0210, data: 8'h3C});
    start_cycle(16'h0210, 1'b1, 8'h00, 1'b0);
    chk++; if ({rdy, cs_ram} !== 2'b01) $display("FAIL rst_next_k got=%0b exp=01", {rdy, cs_ram}); else pass++;
    tick(); tick();
    chk++; if ({mem_re, mem_addr} !== {1'b1, 16'h0210}) $display("FAIL rst_next_re got=%0h exp=%0h", {mem_re, mem_addr}, {1'b1, 16'h0210}); else pass++;
    tick();
    e = sb.pop_front();
    chk++; if ({rdy, cpu_rdata} !== {1'b1, e.data}) $display("FAIL rst_next_rdata got=%0h exp=%0h", {rdy, cpu_rdata}, {1'b1, e.data}); else pass++;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rom_read();
    test_ram_write();
    test_io_read();
    test_io_timeout();
    test_rom_write_overrun();
    test_reset_mid_io();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Downstream of the 65C02 core top level. Consumes the core's address bus, rwb, sync, phi2 and write data.
- Decodes each bus cycle into RAM, ROM or IO space and inserts wait states by holding rdy low.
- Strobes the selected device, then returns read data to the core's data bus input.
- Everything runs on one fast clock; phi2 is sampled as an ordinary input.

Parameters:
- ROM_BASE, 16'hE000, first ROM address; ROM spans ROM_BASE..16'hFFFF.
- IO_BASE, 16'hD000, first address of the 256-byte IO page; IO spans IO_BASE..IO_BASE+16'h00FF.
- RAM_WAIT, 1, wait clocks inserted before the RAM strobe (0..7).
- ROM_WAIT, 0, wait clocks inserted before the ROM strobe (0..7).
- IO_WAIT, 2, wait clocks inserted before the IO strobe (0..7).
- IO_TIMEOUT, 15, maximum clocks spent in STROBE waiting for io_ack (1..255).

Ports:
- clk  input  1  fast system clock.
- reset  input  1  asynchronous, active-high reset.
- phi2  input  1  core phi2; a bus cycle starts on its rising edge.
- a  input  16  core address.
- rwb  input  1  1 = read, 0 = write.
- sync  input  1  opcode fetch marker.
- cpu_wdata  input  8  core write data.
- cpu_rdata  output  8  read data returned to the core.
- rdy  output  1  to core rdy; 0 stalls the core.
- mem_addr  output  16  latched address.
- mem_wdata  output  8  latched write data.
- mem_re  output  1  read strobe.
- mem_we  output  1  write strobe.
- cs_ram  output  1  RAM select.
- cs_rom  output  1  ROM select.
- cs_io  output  1  IO select.
- mem_rdata  input  8  RAM/ROM read data, valid while mem_re is high.
- io_rdata  input  8  IO read data, valid when io_ack is high.
- io_ack  input  1  IO completion.
- fetch  output  1  latched sync for the current cycle.
- err_clr  input  1  clears all sticky error flags.
- rom_wr_err  output  1  sticky: a write targeted ROM.
- io_timeout_err  output  1  sticky: an IO access timed out.
- overrun_err  output  1  sticky: a cycle started while the bridge was busy.

Behaviour:
- Reset values: rdy=1; cpu_rdata=8'hFF; mem_addr=0; mem_wdata=0; all strobes, chip selects, fetch and error flags 0; phi2_q=0; state IDLE.
- Reset is asynchronous. Asserting it mid-access abandons the access, drops mem_we and mem_re immediately, and completes no write.
- Cycle start: start = phi2 & ~phi2_q, where phi2_q is phi2 registered on clk.
- Address decode priority: IO, then ROM, then RAM.
- Region wait W is RAM_WAIT, ROM_WAIT or IO_WAIT.
- Every output is registered.
- States: IDLE, WAIT, STROBE, DONE.
- IDLE, on start at clock edge k:
  - latch a into mem_addr, cpu_wdata into mem_wdata, sync into fetch; assert the selected cs_*.
  - if W=0 and the region is not IO: go to STROBE, rdy stays 1.
  - otherwise: rdy<=0; go to WAIT with cnt=W if W>0, or directly to STROBE if W=0 (IO with zero waits).
- WAIT: decrement cnt each clock; go to STROBE on the edge where cnt reaches 0. Strobes are first visible after edge k+1+W.
- STROBE, RAM/ROM: exactly one clock with mem_re=rwb, or mem_we=~rwb & ~cs_rom.
  - ROM write: no mem_we pulse; rom_wr_err<=1.
  - Read: cpu_rdata<=mem_rdata on the exit edge.
  - Go to DONE.
- STROBE, IO: hold mem_re or mem_we until io_ack=1, counting clocks.
  - On io_ack: capture io_rdata on reads; go to DONE.
  - If IO_TIMEOUT clocks pass without io_ack: cpu_rdata<=8'hFF on reads, io_timeout_err<=1, go to DONE.
  - If io_ack and the timeout land on the same clock, io_ack wins.
- DONE: strobes and chip selects 0, rdy<=1, go to IDLE on the next edge.
- Write data: cpu_rdata is unchanged by writes.
- start outside IDLE: ignored, overrun_err<=1, no state change.
- err_clr clears all sticky flags. If err_clr and a set condition coincide, the set wins.
- Address arithmetic: the IO page bound is computed in 16 bits; an IO_BASE near the top of memory wraps and is not supported (parameter legality only).

Test Plan:
- ROM read at 16'hFFFC, mem_rdata=8'h00, phi2 rising at edge k -> mem_re and cs_rom high for one clock after edge k+1; cpu_rdata=8'h00 after k+2; rdy never low.
- RAM write of 8'h5A to 16'h0200, RAM_WAIT=1 -> rdy low after k; mem_we high for one clock after k+2 with mem_addr=16'h0200 and mem_wdata=8'h5A; rdy=1 after k+3.
- IO read at 16'hD010, io_ack asserted 3 clocks into STROBE with io_rdata=8'hA5 -> cpu_rdata=8'hA5; rdy low throughout; no error flags.
- IO read with io_ack held 0 -> timeout after 15 STROBE clocks; cpu_rdata=8'hFF; io_timeout_err=1; err_clr pulse then returns it to 0.
- Write to 16'hE123 -> mem_we never asserted; rom_wr_err=1. A second phi2 edge during WAIT -> overrun_err=1 and the first access completes normally.
- reset asserted during an IO STROBE -> mem_we, mem_re and cs_io drop asynchronously; rdy=1; the next cycle after reset release decodes normally.
